// File: rtl/axil_decoder_wr_if.sv
// Bundle of the AXI-Lite write-side signals seen by the write decoder:
// upstream master, broadcast/per-slave downstream ports and the invalid-address responder.
interface axil_decoder_wr_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_SLAVES     = 4
);
  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr;
  logic                        s_axil_awvalid;
  logic                        s_axil_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb;
  logic                        s_axil_wvalid;
  logic                        s_axil_wready;
  logic [1:0]                  s_axil_bresp;
  logic                        s_axil_bvalid;
  logic                        s_axil_bready;

  logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr;
  logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb;
  logic [NUM_SLAVES-1:0]       m_axil_awvalid;
  logic [NUM_SLAVES-1:0]       m_axil_wvalid;
  logic [NUM_SLAVES-1:0]       m_axil_bready;
  logic [NUM_SLAVES-1:0]       m_axil_awready;
  logic [NUM_SLAVES-1:0]       m_axil_wready;
  logic [NUM_SLAVES-1:0]       m_axil_bvalid;
  logic [2*NUM_SLAVES-1:0]     m_axil_bresp;

  logic                        slv_invalid;
  logic                        inv_axil_awready;
  logic                        inv_axil_wready;
  logic                        inv_axil_bvalid;
  logic [1:0]                  inv_axil_bresp;
  logic                        inv_axil_bready;

  modport slave (
    input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid, s_axil_bready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    output m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
    input  m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp,
    output slv_invalid, inv_axil_bready,
    input  inv_axil_awready, inv_axil_wready, inv_axil_bvalid, inv_axil_bresp
  );

  modport master (
    output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid, s_axil_bready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    input  m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
    output m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp,
    input  slv_invalid, inv_axil_bready,
    output inv_axil_awready, inv_axil_wready, inv_axil_bvalid, inv_axil_bresp
  );
endinterface

// File: rtl/axil_decoder_wr.sv
// AXI-Lite write-channel decoder: routes AW/W/B between one master and NUM_SLAVES
// base/mask windows, falling back to the invalid-address responder on a miss.
module axil_decoder_wr #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*AXI_ADDR_WIDTH-1:0] SLV_BASE =
    {32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000},
  parameter logic [NUM_SLAVES*AXI_ADDR_WIDTH-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_F000}}
) (
  input logic          aclk,
  input logic          areset,
  axil_decoder_wr_if.slave bus
);
  localparam int N  = NUM_SLAVES;
  localparam int AW = AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t       state, state_n;
  logic [N:0]   sel, sel_n, dec_sel;
  logic         aw_done, aw_done_n, w_done, w_done_n;
  logic         slv_invalid, slv_invalid_n;
  logic         in_fwd, in_resp;
  logic         sel_awready, sel_wready, sel_bvalid;
  logic [1:0]   sel_bresp;
  logic         awready, wready, bvalid, aw_hs, w_hs;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dec_sel    = '0;
    dec_sel[N] = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if ((bus.s_axil_awaddr & SLV_MASK[i*AW +: AW]) ==
          (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_bresp = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) sel_bresp = sel_bresp | bus.m_axil_bresp[2*i +: 2];
    end
    if (sel[N]) sel_bresp = sel_bresp | bus.inv_axil_bresp;
  end

  assign in_fwd      = (state == FWD);
  assign in_resp     = (state == RESP);
  assign sel_awready = (|(sel[N-1:0] & bus.m_axil_awready)) | (sel[N] & bus.inv_axil_awready);
  assign sel_wready  = (|(sel[N-1:0] & bus.m_axil_wready))  | (sel[N] & bus.inv_axil_wready);
  assign sel_bvalid  = (|(sel[N-1:0] & bus.m_axil_bvalid))  | (sel[N] & bus.inv_axil_bvalid);

  assign awready = in_fwd & sel_awready & ~aw_done;
  assign wready  = in_fwd & sel_wready & ~w_done;
  assign bvalid  = in_resp & sel_bvalid;
  assign aw_hs   = bus.s_axil_awvalid & awready;
  assign w_hs    = bus.s_axil_wvalid & wready;

  assign bus.s_axil_awready  = awready;
  assign bus.s_axil_wready   = wready;
  assign bus.s_axil_bvalid   = bvalid;
  assign bus.s_axil_bresp    = in_resp ? sel_bresp : 2'b00;
  assign bus.m_axil_awaddr   = bus.s_axil_awaddr;
  assign bus.m_axil_wdata    = bus.s_axil_wdata;
  assign bus.m_axil_wstrb    = bus.s_axil_wstrb;
  assign bus.m_axil_awvalid  = sel[N-1:0] & {N{in_fwd & bus.s_axil_awvalid & ~aw_done}};
  assign bus.m_axil_wvalid   = sel[N-1:0] & {N{in_fwd & bus.s_axil_wvalid & ~w_done}};
  assign bus.m_axil_bready   = sel[N-1:0] & {N{in_resp & bus.s_axil_bready}};
  assign bus.inv_axil_bready = sel[N] & in_resp & bus.s_axil_bready;
  assign bus.slv_invalid     = slv_invalid;

  always_comb begin
    state_n       = state;
    sel_n         = sel;
    aw_done_n     = aw_done;
    w_done_n      = w_done;
    slv_invalid_n = slv_invalid;
    case (state)
      IDLE: begin
        if (bus.s_axil_awvalid && bus.s_axil_wvalid) begin
          sel_n         = dec_sel;
          slv_invalid_n = dec_sel[N];
          state_n       = FWD;
        end
      end
      FWD: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = RESP;
        end
      end
      RESP: begin
        if (bvalid && bus.s_axil_bready) begin
          sel_n         = '0;
          slv_invalid_n = 1'b0;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      sel         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      slv_invalid <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      aw_done     <= aw_done_n;
      w_done      <= w_done_n;
      slv_invalid <= slv_invalid_n;
    end
  end
endmodule
